// File: rtl/bnn_conv_acc_if.sv
// Pixel-in / window-sum-out bundle for the binary 3x3 convolution accumulator.
// Carries the frame-start/valid qualified pixel stream, kernel and threshold in,
// and the registered sum, binarised bit, valid and end-of-frame strobes out.
interface bnn_conv_acc_if #(
    parameter int CH = 4,
    parameter int OL = 7
);
    logic                 iSTART;
    logic                 iVALID;
    logic [CH-1:0]        iDATA;
    logic [9*CH-1:0]      iWEIGHT;
    logic signed [OL-1:0] iTHRESH;
    logic signed [OL-1:0] oDATA;
    logic                 oBIN;
    logic                 oVALID;
    logic                 oDONE;

    modport master (
        output iSTART, iVALID, iDATA, iWEIGHT, iTHRESH,
        input  oDATA, oBIN, oVALID, oDONE
    );

    modport slave (
        input  iSTART, iVALID, iDATA, iWEIGHT, iTHRESH,
        output oDATA, oBIN, oVALID, oDONE
    );
endinterface

// File: rtl/bnn_conv_acc.sv
// Binary 3x3 XNOR-popcount convolution over CH channels with signed threshold.
// Latency: one cycle from pixel acceptance to oVALID/oDATA/oBIN/oDONE.
// No backpressure: pixels are taken whenever iVALID is high; stalls of any length are free.
module bnn_conv_acc #(
    parameter int IMG_W = 14,
    parameter int IMG_H = 14,
    parameter int CH    = 4,
    parameter int OL    = 7
) (
    input  logic          iCLK,
    input  logic          iRST,
    bnn_conv_acc_if.slave bus
);
    // One shift chain per channel: taps 0..2 are the newest row of the window,
    // IMG_W..IMG_W+2 the row above and 2*IMG_W..2*IMG_W+2 two rows up. The bits
    // between the tap groups are the two line buffers of IMG_W-3 bits each.
    localparam int SR_LEN = 2 * IMG_W + 3;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [OL-1:0] SUM_BIAS = OL'(9 * CH);

    logic [SR_LEN-1:0] winSr   [CH];
    logic [SR_LEN-1:0] nextSr  [CH];
    logic [CW-1:0]     colCnt;
    logic [RW-1:0]     rowCnt;
    logic [CW-1:0]     curCol;
    logic [RW-1:0]     curRow;
    logic [CW-1:0]     nxtCol;
    logic [RW-1:0]     nxtRow;
    logic              winValid;
    logic              lastPix;
    logic [OL-1:0]     popSum;
    logic [OL-1:0]     sumVal;
    logic              binVal;

    // Position of the pixel on the bus: iSTART overrides the counters to (0,0).
    always_comb begin
        curCol   = bus.iSTART ? '0 : colCnt;
        curRow   = bus.iSTART ? '0 : rowCnt;
        winValid = (curRow >= RW'(2)) && (curCol >= CW'(2));
        lastPix  = (curRow == ROW_LAST) && (curCol == COL_LAST);
        if (curCol == COL_LAST) begin
            nxtCol = '0;
            nxtRow = (curRow == ROW_LAST) ? '0 : curRow + RW'(1);
        end else begin
            nxtCol = curCol + CW'(1);
            nxtRow = curRow;
        end
    end

    // Window contents as they will be after accepting the current pixel.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            nextSr[c] = {winSr[c][SR_LEN-2:0], bus.iDATA[c]};
        end
    end

    // XNOR popcount across all channels, then map to +/-1 arithmetic and threshold.
    // Sum fits OL bits exactly, so modular subtraction yields the signed result.
    always_comb begin
        popSum = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 9; k++) begin
                popSum = popSum + {{(OL-1){1'b0}},
                    ~(nextSr[c][(k / 3) * IMG_W + (k % 3)] ^ bus.iWEIGHT[9 * c + k])};
            end
        end
        sumVal = (popSum << 1) - SUM_BIAS;
        binVal = ($signed(sumVal) >= bus.iTHRESH);
    end

    // Pixel shift chains and raster counters; iSTART alone just rewinds the counters.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int c = 0; c < CH; c++) begin
                winSr[c] <= '0;
            end
            colCnt <= '0;
            rowCnt <= '0;
        end else if (bus.iVALID) begin
            for (int c = 0; c < CH; c++) begin
                winSr[c] <= nextSr[c];
            end
            colCnt <= nxtCol;
            rowCnt <= nxtRow;
        end else if (bus.iSTART) begin
            colCnt <= '0;
            rowCnt <= '0;
        end
    end

    // Registered result; data/bin hold their last value when no window completes.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            bus.oDATA  <= '0;
            bus.oBIN   <= 1'b0;
            bus.oVALID <= 1'b0;
            bus.oDONE  <= 1'b0;
        end else begin
            bus.oVALID <= bus.iVALID && winValid;
            bus.oDONE  <= bus.iVALID && winValid && lastPix;
            if (bus.iVALID && winValid) begin
                bus.oDATA <= $signed(sumVal);
                bus.oBIN  <= binVal;
            end
        end
    end
endmodule

// File: tb/tb_bnn_conv_acc.sv
// Scoreboard bench for bnn_conv_acc: an image-indexed reference model predicts
// every window result at issue time; a negedge monitor pops and compares value,
// binarisation, end-of-frame flag and one-cycle latency.
module tb_bnn_conv_acc;
    localparam int IMG_W = 14;
    localparam int IMG_H = 14;
    localparam int CH    = 4;
    localparam int OL    = 7;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);

    typedef struct {
        int s;
        int b;
        int d;
        int stamp;
    } exp_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   cyc  = 0;
    int   tests = 0;
    int   fails = 0;
    int   validCnt = 0;
    int   doneCnt  = 0;
    int   lastData = 0;
    int   lastBin  = 0;
    int   mr = 0;
    int   mc = 0;

    exp_t sbQ[$];
    logic [CH-1:0]        img [IMG_H][IMG_W];
    logic [9*CH-1:0]      wgt;
    logic signed [OL-1:0] thr;

    bnn_conv_acc_if #(.CH(CH), .OL(OL)) bus ();

    bnn_conv_acc #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .OL(OL)) dut (
        .iCLK (clk),
        .iRST (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.iWEIGHT = wgt;
    assign bus.iTHRESH = thr;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: place the pixel in a frame image and, when a full 3x3 window
    // exists, sum +/-1 agreements against the kernel directly from the image.
    function automatic void modelPix(input bit start, input logic [CH-1:0] d);
        int p;
        int s;
        exp_t e;
        if (start) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
            p = 0;
            for (int ch = 0; ch < CH; ch++)
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        if (img[mr-dr][mc-dc][ch] == wgt[9*ch + 3*dr + dc]) p++;
            s = 2 * p - 9 * CH;
            e.s = s;
            e.b = (s >= int'(thr)) ? 1 : 0;
            e.d = (mr == IMG_H - 1 && mc == IMG_W - 1) ? 1 : 0;
            e.stamp = cyc;
            sbQ.push_back(e);
        end
        mc++;
        if (mc == IMG_W) begin
            mc = 0;
            mr++;
            if (mr == IMG_H) mr = 0;
        end
    endfunction

    task automatic pix(input bit start, input logic [CH-1:0] d);
        @(negedge clk);
        bus.iSTART = start;
        bus.iVALID = 1'b1;
        bus.iDATA  = d;
        modelPix(start, d);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.iSTART = 1'b0;
        bus.iVALID = 1'b0;
        bus.iDATA  = CH'($urandom);
    endtask

    // dataMode: 0 random, 1 all ones. gapPct: chance of an idle before each pixel.
    task automatic frame(input bit withStart, input int gapPct, input int nPix, input int dataMode);
        logic [CH-1:0] d;
        for (int i = 0; i < nPix; i++) begin
            while (int'($urandom_range(99)) < gapPct) idle();
            d = (dataMode == 1) ? '1 : CH'($urandom);
            pix(withStart && (i == 0), d);
        end
    endtask

    task automatic drain(input string nm);
        repeat (4) idle();
        chk({nm, "_sb_empty"}, sbQ.size(), 0);
    endtask

    task automatic randKernel();
        int t;
        for (int i = 0; i < 9 * CH; i++) wgt[i] = 1'($urandom_range(1));
        t = int'($urandom_range(80)) - 40;
        thr = t[OL-1:0];
    endtask

    // Monitor: every cycle out of reset, either match a predicted result or
    // confirm outputs are idle and holding.
    always @(negedge clk) begin
        exp_t e;
        if (rstN) begin
            if (bus.oVALID) begin
                validCnt++;
                if (bus.oDONE) doneCnt++;
                if (sbQ.size() == 0) begin
                    chk("unexpected_ovalid", 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    chk("odata", int'(bus.oDATA), e.s);
                    chk("obin", int'(bus.oBIN), e.b);
                    chk("odone", int'(bus.oDONE), e.d);
                    chk("latency", cyc, e.stamp + 1);
                end
                lastData = int'(bus.oDATA);
                lastBin  = int'(bus.oBIN);
            end else begin
                chk("odone_without_ovalid", int'(bus.oDONE), 0);
                chk("odata_hold", int'(bus.oDATA), lastData);
                chk("obin_hold", int'(bus.oBIN), lastBin);
            end
        end else begin
            lastData = 0;
            lastBin  = 0;
        end
    end

    initial begin
        bus.iSTART = 1'b0;
        bus.iVALID = 1'b0;
        bus.iDATA  = '0;
        wgt = '1;
        thr = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_odata", int'(bus.oDATA), 0);
        chk("rst_obin", int'(bus.oBIN), 0);
        chk("rst_ovalid", int'(bus.oVALID), 0);
        chk("rst_odone", int'(bus.oDONE), 0);
        @(negedge clk);
        #2 rstN = 1'b1;

        // All ones data, all ones kernel, threshold 0: +36 everywhere
        validCnt = 0; doneCnt = 0;
        frame(1'b1, 0, NPIX, 1);
        drain("ones");
        chk("ones_count", validCnt, NOUT);
        chk("ones_done", doneCnt, 1);
        chk("ones_last_value", lastData, 36);

        // All zero kernel: -36, bin 0
        wgt = '0;
        validCnt = 0; doneCnt = 0;
        frame(1'b1, 0, NPIX, 1);
        drain("zeros");
        chk("zeros_count", validCnt, NOUT);
        chk("zeros_last_value", lastData, -36);

        // Random content, two back-to-back frames, second without iSTART
        randKernel();
        validCnt = 0; doneCnt = 0;
        frame(1'b1, 0, NPIX, 0);
        frame(1'b0, 0, NPIX, 0);
        drain("b2b");
        chk("b2b_count", validCnt, 2 * NOUT);
        chk("b2b_done", doneCnt, 2);

        // Random stalls, pixel valid roughly a quarter of the time
        randKernel();
        validCnt = 0; doneCnt = 0;
        frame(1'b1, 75, NPIX, 0);
        drain("gaps");
        chk("gaps_count", validCnt, NOUT);
        chk("gaps_done", doneCnt, 1);

        // Restart at pixel 100: abandoned frame yields no oDONE
        randKernel();
        validCnt = 0; doneCnt = 0;
        frame(1'b1, 0, 100, 0);
        frame(1'b1, 0, NPIX, 0);
        drain("restart");
        chk("restart_done", doneCnt, 1);
        chk("restart_count", validCnt, (100 / IMG_W - 2) * (IMG_W - 2) + 100 % IMG_W - 2 + NOUT);

        // iSTART with iVALID low rewinds; following frame carries no iSTART
        randKernel();
        validCnt = 0; doneCnt = 0;
        frame(1'b0, 0, 57, 0);
        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iVALID = 1'b0;
        mr = 0;
        mc = 0;
        frame(1'b0, 20, NPIX, 0);
        drain("rewind");
        chk("rewind_done", doneCnt, 1);

        // Asynchronous reset mid-frame
        randKernel();
        frame(1'b1, 0, 80, 0);
        @(posedge clk);
        #2;
        bus.iVALID = 1'b0;
        rstN = 1'b0;
        #1;
        chk("arst_odata", int'(bus.oDATA), 0);
        chk("arst_obin", int'(bus.oBIN), 0);
        chk("arst_ovalid", int'(bus.oVALID), 0);
        chk("arst_odone", int'(bus.oDONE), 0);
        sbQ.delete();
        mr = 0;
        mc = 0;
        repeat (3) @(negedge clk);
        #2 rstN = 1'b1;
        validCnt = 0; doneCnt = 0;
        frame(1'b0, 0, NPIX, 0);
        drain("post_rst");
        chk("post_rst_count", validCnt, NOUT);
        chk("post_rst_done", doneCnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
